// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS function generator control path.
//   - Waveform encodings (WAVE_SINE .. WAVE_SAW) and the wrap-around
//     advance helper nextWave().
//   - The step-size table STEP_TABLE[0:3] = 1, 10, 100, 1000 and its
//     lookup helper stepValue().
//   - Load-handshake FSM state encoding (ST_IDLE, ST_VALID).
// Optional feature macro used by the importing modules: DOWN_BTN_EN.
package dds_pkg;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  // Wide enough for the largest step (1000); callers zero-extend to FTW_W.
  localparam int STEP_W = 11;

  localparam logic [STEP_W-1:0] STEP_TABLE [0:3] = '{
    11'd1, 11'd10, 11'd100, 11'd1000
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  function automatic logic [STEP_W-1:0] stepValue(input logic [1:0] idx);
    return STEP_TABLE[idx];
  endfunction

  function automatic logic [1:0] nextWave(input logic [1:0] wave);
    logic [1:0] nxt;
    case (wave)
      WAVE_SINE:   nxt = WAVE_SQUARE;
      WAVE_SQUARE: nxt = WAVE_TRI;
      WAVE_TRI:    nxt = WAVE_SAW;
      default:     nxt = WAVE_SINE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dds_param_ctrl_ftw_step_alu.sv
// ftw_step_alu: combinational update of the shadow tuning word by one step.
// Ports:
//   ftw_i   current shadow FTW
//   step_i  step amount (already zero-extended to FTW_W)
//   up_i    raise request
//   down_i  lower request (only present with DOWN_BTN_EN)
//   ftw_o   next shadow FTW
// Macro DOWN_BTN_EN:
//   defined   - up saturates at FTW_MAX, down saturates at FTW_MIN,
//               up and down together leave the value unchanged.
//   undefined - up wraps to FTW_MIN when the sum would exceed FTW_MAX.
module ftw_step_alu
  import dds_pkg::*;
#(
  parameter int               FTW_W   = 32,
  parameter logic [FTW_W-1:0] FTW_MIN = 1,
  parameter logic [FTW_W-1:0] FTW_MAX = 1000000
) (
  input  logic [FTW_W-1:0] ftw_i,
  input  logic [FTW_W-1:0] step_i,
  input  logic             up_i,
`ifdef DOWN_BTN_EN
  input  logic             down_i,
`endif
  output logic [FTW_W-1:0] ftw_o
);

  // One extra bit keeps the carry/borrow visible to the limit checks.
  logic [FTW_W:0] sum;
`ifdef DOWN_BTN_EN
  logic [FTW_W:0] diff;
`endif

  always_comb begin
    sum   = {1'b0, ftw_i} + {1'b0, step_i};
    ftw_o = ftw_i;
`ifdef DOWN_BTN_EN
    diff  = {1'b0, ftw_i} - {1'b0, step_i};
    if (up_i && !down_i) begin
      ftw_o = (sum > {1'b0, FTW_MAX}) ? FTW_MAX : sum[FTW_W-1:0];
    end else if (down_i && !up_i) begin
      // A set top bit means the subtraction borrowed past zero.
      ftw_o = (diff[FTW_W] || (diff[FTW_W-1:0] < FTW_MIN)) ? FTW_MIN
                                                          : diff[FTW_W-1:0];
    end
`else
    if (up_i) begin
      ftw_o = (sum > {1'b0, FTW_MAX}) ? FTW_MIN : sum[FTW_W-1:0];
    end
`endif
  end

endmodule

// File: rtl/dds_param_ctrl.sv
// dds_param_ctrl: turns debounced button pulses into waveform / tuning-word
// settings and hands committed values to the DDS core over a valid/ready
// load handshake. Runs entirely in the Fg_clk domain.
// Ports:
//   Fg_clk     system clock
//   Reset      asynchronous, active-high reset
//   Btn_mode   press pulse, advances the waveform
//   Btn_up     press pulse, raises the FTW by the current step
//   Btn_down   press pulse, lowers the FTW by the current step (DOWN_BTN_EN)
//   Btn_step   press pulse, advances the step-size index
//   Wave_sel   committed waveform (0 sine, 1 square, 2 triangle, 3 sawtooth)
//   Ftw        committed tuning word
//   Step_idx   live step-size index
//   Ftw_valid  committed load pending to the DDS core
//   Ftw_ready  DDS core accepts the load
// Macro DOWN_BTN_EN adds Btn_down and makes up/down saturate; without it
// Btn_up wraps to FTW_MIN past FTW_MAX.
module dds_param_ctrl
  import dds_pkg::*;
#(
  parameter int               FTW_W       = 32,
  parameter logic [FTW_W-1:0] FTW_DEFAULT = 1000,
  parameter logic [FTW_W-1:0] FTW_MIN     = 1,
  parameter logic [FTW_W-1:0] FTW_MAX     = 1000000
) (
  input  logic             Fg_clk,
  input  logic             Reset,
  input  logic             Btn_mode,
  input  logic             Btn_up,
`ifdef DOWN_BTN_EN
  input  logic             Btn_down,
`endif
  input  logic             Btn_step,
  output logic [1:0]       Wave_sel,
  output logic [FTW_W-1:0] Ftw,
  output logic [1:0]       Step_idx,
  output logic             Ftw_valid,
  input  logic             Ftw_ready
);

  logic [1:0]       waveShadow_q, waveShadow_d;
  logic [FTW_W-1:0] ftwShadow_q,  ftwShadow_d;
  logic [1:0]       stepShadow_q, stepShadow_d;
  logic             dirty_q,      dirty_d;

  state_e           state_q;
  logic [1:0]       waveSel_q;
  logic [FTW_W-1:0] ftw_q;
  logic             ftwValid_q;

  logic             anyPress;
  logic             loadNow;
  logic [FTW_W-1:0] stepAmount;
  logic [FTW_W-1:0] aluFtw;

  // The FTW update uses the step held before any same-cycle Btn_step.
  assign stepAmount = FTW_W'(stepValue(stepShadow_q));

  ftw_step_alu #(
    .FTW_W   (FTW_W),
    .FTW_MIN (FTW_MIN),
    .FTW_MAX (FTW_MAX)
  ) u_alu (
    .ftw_i  (ftwShadow_q),
    .step_i (stepAmount),
    .up_i   (Btn_up),
`ifdef DOWN_BTN_EN
    .down_i (Btn_down),
`endif
    .ftw_o  (aluFtw)
  );

  // Shadow next-state. A load consumes dirty, but a press in the same cycle
  // re-arms it so the newest values are never lost.
  always_comb begin
    anyPress = Btn_mode | Btn_up | Btn_step;
`ifdef DOWN_BTN_EN
    anyPress = anyPress | Btn_down;
`endif
    loadNow      = dirty_q && ((state_q == ST_IDLE) || Ftw_ready);
    waveShadow_d = Btn_mode ? nextWave(waveShadow_q) : waveShadow_q;
    stepShadow_d = Btn_step ? (stepShadow_q + 2'd1) : stepShadow_q;
    ftwShadow_d  = aluFtw;
    dirty_d      = anyPress | (dirty_q & ~loadNow);
  end

  // Reset leaves dirty set so the defaults go out as the first transaction.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      waveShadow_q <= WAVE_SINE;
      ftwShadow_q  <= FTW_DEFAULT;
      stepShadow_q <= 2'd0;
      dirty_q      <= 1'b1;
    end else begin
      waveShadow_q <= waveShadow_d;
      ftwShadow_q  <= ftwShadow_d;
      stepShadow_q <= stepShadow_d;
      dirty_q      <= dirty_d;
    end
  end

  // Load handshake FSM. Outputs stay frozen while the core stalls; on
  // acceptance with new pending values they reload back-to-back.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      waveSel_q  <= WAVE_SINE;
      ftw_q      <= FTW_DEFAULT;
      ftwValid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (loadNow) begin
            waveSel_q  <= waveShadow_q;
            ftw_q      <= ftwShadow_q;
            ftwValid_q <= 1'b1;
            state_q    <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (Ftw_ready) begin
            if (loadNow) begin
              waveSel_q  <= waveShadow_q;
              ftw_q      <= ftwShadow_q;
              ftwValid_q <= 1'b1;
            end else begin
              ftwValid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
        end
        default: begin
          ftwValid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign Wave_sel  = waveSel_q;
  assign Ftw       = ftw_q;
  assign Step_idx  = stepShadow_q;
  assign Ftw_valid = ftwValid_q;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// tb_dds_param_ctrl: self-checking bench for dds_param_ctrl.
// Directed sequences cover reset, step/up latency, saturation or wrap at
// FTW_MAX, down saturation (with DOWN_BTN_EN), coalescing under stall and
// asynchronous reset; a random phase follows. Every cycle the outputs are
// compared with a transaction-level reference model.
module tb_dds_param_ctrl;

  localparam int     FTW_W       = 32;
  localparam longint FTW_DEFAULT = 1000;
  localparam longint FTW_MIN     = 1;
  localparam longint FTW_MAX     = 1000000;
`ifdef DOWN_BTN_EN
  localparam bit     DOWN_EN     = 1'b1;
`else
  localparam bit     DOWN_EN     = 1'b0;
`endif

  logic             Fg_clk   = 1'b0;
  logic             Reset    = 1'b0;
  logic             btnMode  = 1'b0;
  logic             btnUp    = 1'b0;
  logic             btnDown  = 1'b0;
  logic             btnStep  = 1'b0;
  logic             ftwReady = 1'b0;
  logic [1:0]       waveSel;
  logic [FTW_W-1:0] ftw;
  logic [1:0]       stepIdx;
  logic             ftwValid;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: user settings, a pending-change flag, and what the
  // core currently sees on the load interface.
  int     mWave;
  longint mFtw;
  int     mStepIdx;
  bit     mPending;
  bit     mValid;
  int     mOutWave;
  longint mOutFtw;
  int     stepSizes [4] = '{1, 10, 100, 1000};

  always #5 Fg_clk = ~Fg_clk;

  dds_param_ctrl #(
    .FTW_W       (FTW_W),
    .FTW_DEFAULT (32'(FTW_DEFAULT)),
    .FTW_MIN     (32'(FTW_MIN)),
    .FTW_MAX     (32'(FTW_MAX))
  ) dut (
    .Fg_clk    (Fg_clk),
    .Reset     (Reset),
    .Btn_mode  (btnMode),
    .Btn_up    (btnUp),
`ifdef DOWN_BTN_EN
    .Btn_down  (btnDown),
`endif
    .Btn_step  (btnStep),
    .Wave_sel  (waveSel),
    .Ftw       (ftw),
    .Step_idx  (stepIdx),
    .Ftw_valid (ftwValid),
    .Ftw_ready (ftwReady)
  );

  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mWave    = 0;
    mFtw     = FTW_DEFAULT;
    mStepIdx = 0;
    mPending = 1'b1;
    mValid   = 1'b0;
    mOutWave = 0;
    mOutFtw  = FTW_DEFAULT;
  endtask

  // One clock edge of the reference model, using pre-edge state throughout.
  task automatic modelEdge(input bit mode, input bit up, input bit down,
                           input bit step, input bit ready);
    bit     sendNow;
    longint amount;
    sendNow = mPending && (!mValid || ready);
    if (sendNow) begin
      mOutWave = mWave;
      mOutFtw  = mFtw;
      mValid   = 1'b1;
    end else if (mValid && ready) begin
      mValid = 1'b0;
    end
    mPending = (mPending && !sendNow) || mode || up || down || step;
    amount = stepSizes[mStepIdx];
    if (up && !down) begin
      if (mFtw + amount > FTW_MAX) mFtw = DOWN_EN ? FTW_MAX : FTW_MIN;
      else                         mFtw = mFtw + amount;
    end else if (down && !up) begin
      if (mFtw - amount < FTW_MIN) mFtw = FTW_MIN;
      else                         mFtw = mFtw - amount;
    end
    if (mode) mWave = (mWave + 1) % 4;
    if (step) mStepIdx = (mStepIdx + 1) % 4;
  endtask

  task automatic checkAgainstModel();
    checkOutput("wave_sel",  longint'(waveSel),  longint'(mOutWave));
    checkOutput("ftw",       longint'(ftw),      mOutFtw);
    checkOutput("step_idx",  longint'(stepIdx),  longint'(mStepIdx));
    checkOutput("ftw_valid", longint'(ftwValid), longint'(mValid));
  endtask

  // Called at a falling edge: drive one cycle of inputs, let the rising
  // edge happen, then compare at the next falling edge.
  task automatic applyStimulus(input bit mode, input bit up, input bit down,
                               input bit step, input bit ready);
    bit downEff;
    downEff  = DOWN_EN ? down : 1'b0;
    btnMode  = mode;
    btnUp    = up;
    btnDown  = downEff;
    btnStep  = step;
    ftwReady = ready;
    @(posedge Fg_clk);
    modelEdge(mode, up, downEff, step, ready);
    @(negedge Fg_clk);
    btnMode = 1'b0;
    btnUp   = 1'b0;
    btnDown = 1'b0;
    btnStep = 1'b0;
    checkAgainstModel();
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, ready);
  endtask

  task automatic press(input int n, input bit mode, input bit up,
                       input bit down, input bit step, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(mode, up, down, step, ready);
  endtask

  // Reset is raised between clock edges so the output drop must be
  // asynchronous to be seen.
  task automatic doReset();
    #2;
    Reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_valid", longint'(ftwValid), 0);
    checkOutput("rst_ftw",   longint'(ftw),      FTW_DEFAULT);
    checkOutput("rst_wave",  longint'(waveSel),  0);
    checkOutput("rst_step",  longint'(stepIdx),  0);
    @(negedge Fg_clk);
    Reset = 1'b0;
  endtask

  initial begin
    @(negedge Fg_clk);

    // Reset release with a stalled core: defaults go out and are held.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("first_valid", longint'(ftwValid), 1);
    checkOutput("first_ftw",   longint'(ftw),      FTW_DEFAULT);
    idle(3, 1'b0);
    checkOutput("held_valid",  longint'(ftwValid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("accept_drop", longint'(ftwValid), 0);

    // Two step presses then up: step 100 gives 1100, valid two cycles on.
    doReset();
    idle(2, 1'b1);
    press(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("step_idx2", longint'(stepIdx), 2);
    idle(1, 1'b1);
    checkOutput("up_valid",  longint'(ftwValid), 1);
    checkOutput("up_ftw",    longint'(ftw),      1100);

    // Walk the tuning word to 999950, then step past FTW_MAX.
    doReset();
    idle(2, 1'b1);
    press(3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press(998, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    press(3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press(9,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    press(3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press(5,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    checkOutput("near_max", longint'(ftw), 999950);
    press(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    checkOutput("limit_ftw", longint'(ftw), DOWN_EN ? FTW_MAX : FTW_MIN);

`ifdef DOWN_BTN_EN
    // Down saturation at FTW_MIN, then up+down together.
    doReset();
    idle(2, 1'b1);
    press(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    press(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    checkOutput("ftw_at5", longint'(ftw), 5);
    press(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    checkOutput("down_sat", longint'(ftw), FTW_MIN);
    idle(2, 1'b1);
    checkOutput("quiet_valid", longint'(ftwValid), 0);
    press(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    checkOutput("updown_valid", longint'(ftwValid), 1);
    checkOutput("updown_ftw",   longint'(ftw),      FTW_MIN);
`endif

    // Presses during a stalled load are coalesced into one reload.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    press(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_wave", longint'(waveSel), 0);
    checkOutput("stall_ftw",  longint'(ftw),     FTW_DEFAULT);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reload_valid", longint'(ftwValid), 1);
    checkOutput("reload_wave",  longint'(waveSel),  3);
    checkOutput("reload_ftw",   longint'(ftw),      FTW_DEFAULT + 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("single_reload", longint'(ftwValid), 0);

    // Reset while a load is pending and the step index is non-zero.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    checkOutput("pre_rst_valid", longint'(ftwValid), 1);
    doReset();

    // Random phase.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dds_param_ctrl.md
Name: dds_param_ctrl

Overview:
- Sits downstream of the button debouncers in the DDS function generator.
- Consumes their single-cycle press pulses and maintains the user-selected waveform, frequency tuning word (FTW) and step size.
- Delivers the waveform and FTW to the DDS core through a valid/ready load handshake.
- Runs in the Fg_clk domain.

Parameters:
- FTW_W, 32, width of the frequency tuning word.
- FTW_DEFAULT, 1000, FTW loaded at reset.
- FTW_MIN, 1, lowest legal FTW.
- FTW_MAX, 1000000, highest legal FTW.

Ports:
- Fg_clk  in  1  system clock.
- Reset  in  1  asynchronous reset, active-high.
- Btn_mode  in  1  press pulse; advances the waveform.
- Btn_up  in  1  press pulse; raises the FTW by the current step.
- Btn_down  in  1  press pulse; lowers the FTW by the current step. Exists only with DOWN_BTN_EN.
- Btn_step  in  1  press pulse; advances the step size.
- Wave_sel  out  2  committed waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- Ftw  out  FTW_W  committed tuning word.
- Step_idx  out  2  current step-size index (live shadow value).
- Ftw_valid  out  1  committed load is pending to the DDS core.
- Ftw_ready  in  1  DDS core accepts the load.

Behaviour:
- Btn_* are single-cycle pulses, synchronous to Fg_clk, with at most one pulse per input per press.
- Shadow registers: wave_s, ftw_s, step_s and the dirty flag. They update at the clock edge that samples a pulse, and they set dirty.
- Step table (shared package): index 0..3 maps to 1, 10, 100, 1000.
- Btn_step: step_s increments and wraps 3->0. Step_idx is driven directly from step_s.
- Btn_mode: wave_s increments and wraps 3->0.
- Btn_up: ftw_s = min(ftw_s + step, FTW_MAX).
  - The sum is computed at FTW_W+1 bits, so there is no silent overflow.
- Btn_down: ftw_s = max(ftw_s - step, FTW_MIN).
  - Underflow is detected with an FTW_W+1 bit subtraction.
- Simultaneous pulses:
  - Mode, step and frequency actions are independent and all apply in the same cycle.
  - Btn_up and Btn_down together produce no FTW change, but dirty is still set.
  - The FTW arithmetic uses the step value from before any same-cycle Btn_step.
- A saturated press (ftw_s already at its limit) still sets dirty and produces a transaction.
- FSM states:
  - IDLE:
    - If dirty: copy shadows into Wave_sel/Ftw, assert Ftw_valid, clear dirty, go to VALID.
    - Otherwise stay in IDLE.
  - VALID:
    - Wave_sel, Ftw and Ftw_valid are held stable while Ftw_ready=0.
    - On Ftw_ready=1 with dirty=0: deassert Ftw_valid, go to IDLE.
    - On Ftw_ready=1 with dirty=1: reload outputs from the shadows, keep Ftw_valid=1, clear dirty, stay in VALID. This makes back-to-back transactions possible.
- Dirty handling:
  - A pulse arriving in the same cycle dirty is cleared sets dirty again. The set takes priority over the clear.
  - Presses made while a transaction is pending are coalesced. Only the latest shadow values are sent.
- Latency: a pulse in cycle N gives Ftw_valid=1 with the new values in cycle N+2 when the FSM was IDLE.
- Reset (asynchronous, any time):
  - Shadows: wave_s=0, ftw_s=FTW_DEFAULT, step_s=0, dirty=1.
  - Outputs: Wave_sel=0, Ftw=FTW_DEFAULT, Step_idx=0, Ftw_valid=0.
  - FSM goes to IDLE.
  - The first transaction, carrying the default values, starts on the first edge after Reset deasserts.
  - Reset asserted mid-transaction aborts the load immediately; Ftw_valid drops asynchronously.

Optional Feature:
- Macro: DOWN_BTN_EN.
- Defined:
  - The Btn_down port exists.
  - Btn_up and Btn_down both saturate as described above.
- Undefined:
  - There is no Btn_down port.
  - Btn_up wraps: if ftw_s + step > FTW_MAX, then ftw_s = FTW_MIN.
  - Saturation logic for down is omitted.

Decomposition:
- Shared package dds_pkg:
  - Wave encoding constants WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW.
  - Step-table function/constant array STEP_TABLE[0:3].
  - FSM state encoding ST_IDLE, ST_VALID.
- One natural sub-module: ftw_step_alu, the combinational saturate/wrap add/sub of ftw_s by the step.
- The FSM and shadow registers stay in the top module.

Test Plan:
- Reset release with Ftw_ready=0:
  - Ftw_valid=1 with Ftw=1000, Wave_sel=0, one cycle after deassert, held until ready.
  - Pulse Ftw_ready for 1 cycle: Ftw_valid=0 on the next cycle.
- Btn_step x2, then Btn_up, with Ftw_ready=1:
  - Step_idx=2.
  - Final committed Ftw=1100.
  - Ftw_valid asserted 2 cycles after the Btn_up pulse.
- Drive ftw_s to 999950 (step 100), then Btn_up: Ftw=1000000.
  - With DOWN_BTN_EN undefined, the same sequence gives Ftw=1.
- DOWN_BTN_EN defined, ftw_s=5, step 10:
  - Btn_down gives Ftw=1.
  - Btn_up+Btn_down in the same cycle: Ftw unchanged, a transaction still issued.
- Hold Ftw_ready=0 during a pending load, then press Btn_mode x3 and Btn_up x2 (step 1):
  - Outputs remain at the old values until ready.
  - Then exactly one back-to-back reload with Wave_sel=3 and Ftw=old+2.
- Assert Reset while in VALID: Ftw_valid=0 asynchronously, and all outputs return to their defaults.
